// File: rtl/i2c_pkg.sv
// i2c_pkg: shared widths, R/W bit encoding and FSM state encoding for the I2C target.
package i2c_pkg;
    localparam int I2C_ADDR_W = 7;
    localparam int I2C_BYTE_W = 8;
    localparam logic RW_READ = 1'b1;
    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK, S_WDATA, S_WDATA_ACK, S_RDATA, S_RACK
    } state_t;
endpackage

// File: rtl/i2c_line_cond.sv
// i2c_line_cond: 2-flop synchronizer, optional majority glitch filter and edge detect for one bus line.
// Define I2C_SLAVE_GLITCH_FILTER_EN to insert the 3-sample majority filter.
module i2c_line_cond (
    input  logic clk_50,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [1:0] sync;
    logic prev;
    always_ff @(posedge clk_50 or negedge reset)
        if (!reset) sync <= 2'b11;
        else sync <= {sync[0], raw};
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    logic [2:0] hist;
    always_ff @(posedge clk_50 or negedge reset)
        if (!reset) hist <= 3'b111;
        else hist <= {hist[1:0], sync[1]};
    assign level = (hist[0] & hist[1]) | (hist[1] & hist[2]) | (hist[0] & hist[2]);
`else
    assign level = sync[1];
`endif
    always_ff @(posedge clk_50 or negedge reset)
        if (!reset) prev <= 1'b1;
        else prev <= level;
    assign rise = level & ~prev;
    assign fall = ~level & prev;
endmodule

// File: rtl/i2c_slave_target.sv
// i2c_slave_target: I2C target serving a byte register file (pointer write, auto-increment write/read).
// Define I2C_SLAVE_GLITCH_FILTER_EN to add a majority glitch filter on scl/sda.
module i2c_slave_target
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR = 7'h50,
    parameter int NREGS = 4,
    parameter int PTR_W = 2
) (
    input  logic                  clk_50,
    input  logic                  reset,
    inout  wire                   sda,
    input  logic                  scl,
    input  logic [PTR_W-1:0]      host_addr,
    output logic [I2C_BYTE_W-1:0] host_rdata,
    output logic                  busy,
    output logic                  addr_hit,
    output logic                  wr_pulse
);
    state_t state, nxt;
    logic [I2C_BYTE_W-1:0] sr;
    logic [I2C_BYTE_W-1:0] regs [NREGS];
    logic [3:0] cnt;
    logic [PTR_W-1:0] ptr;
    logic nack, drv_low;
    logic scl_lvl, scl_rise, scl_fall, sda_lvl, sda_rise, sda_fall;
    logic start, stop, byte_full, rx_state;

    i2c_line_cond u_scl (.clk_50(clk_50), .reset(reset), .raw(scl), .level(scl_lvl), .rise(scl_rise), .fall(scl_fall));
    i2c_line_cond u_sda (.clk_50(clk_50), .reset(reset), .raw(sda), .level(sda_lvl), .rise(sda_rise), .fall(sda_fall));

    assign start = sda_fall & scl_lvl;
    assign stop = sda_rise & scl_lvl;
    assign byte_full = cnt == 4'd8;
    assign rx_state = state inside {S_ADDR, S_PTR, S_WDATA};
    assign host_rdata = regs[host_addr];
    assign sda = drv_low ? 1'b0 : 1'bz;

    always_ff @(posedge clk_50 or negedge reset)
        if (!reset) state <= S_IDLE;
        else state <= nxt;

    // Byte/ACK boundaries advance on scl falls so sda only ever changes while scl is low.
    always_comb begin
        nxt = state;
        if (stop) nxt = S_IDLE;
        else if (start) nxt = S_ADDR;
        else if (scl_fall)
            case (state)
                S_ADDR:                 if (byte_full) nxt = (sr[I2C_BYTE_W-1:1] == SLAVE_ADDR) ? S_ADDR_ACK : S_IDLE;
                S_ADDR_ACK:             nxt = (sr[0] == RW_READ) ? S_RDATA : S_PTR;
                S_PTR:                  if (byte_full) nxt = S_PTR_ACK;
                S_PTR_ACK, S_WDATA_ACK: nxt = S_WDATA;
                S_WDATA:                if (byte_full) nxt = S_WDATA_ACK;
                S_RDATA:                if (cnt == 4'd7) nxt = S_RACK;
                S_RACK:                 nxt = nack ? S_IDLE : S_RDATA;
                default:                nxt = state;
            endcase
    end

    always_comb begin
        drv_low = (state inside {S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK}) || (state == S_RDATA && !sr[I2C_BYTE_W-1]);
        addr_hit = state == S_ADDR && scl_fall && byte_full && nxt == S_ADDR_ACK;
        wr_pulse = state == S_WDATA && scl_fall && byte_full;
    end

    always_ff @(posedge clk_50 or negedge reset)
        if (!reset) begin
            sr <= '0;
            cnt <= '0;
            ptr <= '0;
            nack <= 1'b0;
            busy <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            if (stop) busy <= 1'b0;
            else if (start) busy <= 1'b1;
            if (start) cnt <= '0;
            else if (scl_rise && rx_state && !byte_full) begin
                sr <= {sr[I2C_BYTE_W-2:0], sda_lvl};
                cnt <= cnt + 4'd1;
            end else if (scl_rise && state == S_RACK) nack <= sda_lvl;
            else if (scl_fall) begin
                if (state == S_RDATA) begin
                    sr <= sr << 1;
                    cnt <= cnt + 4'd1;
                end else if (nxt == S_RDATA) begin
                    sr <= regs[ptr];
                    cnt <= '0;
                end else if (nxt != state) cnt <= '0;
                if (wr_pulse) begin
                    regs[ptr] <= sr;
                    ptr <= ptr + 1'b1;
                end else if (state == S_PTR && byte_full) ptr <= sr[PTR_W-1:0];
                else if (state == S_RDATA && cnt == 4'd7) ptr <= ptr + 1'b1;
            end
        end
endmodule

// File: tb/tb_i2c_slave_target.sv
// tb_i2c_slave_target: bus-functional I2C master with randomized transactions checked against a register-file model.
module tb_i2c_slave_target;
    localparam int Q = 6;
    logic clk_50 = 1'b0, reset = 1'b0, scl = 1'b1, m_sda = 1'b1;
    logic [1:0] host_addr = 2'd0;
    logic [7:0] host_rdata;
    logic busy, addr_hit, wr_pulse;
    wire sda;
    pullup (sda);
    assign sda = m_sda ? 1'bz : 1'b0;

    int checks = 0, errors = 0, hit_cnt = 0, wr_cnt = 0;
    logic [7:0] mregs [4];
    logic [7:0] wbuf [4];
    int mptr = 0;

    i2c_slave_target dut (
        .clk_50(clk_50), .reset(reset), .sda(sda), .scl(scl), .host_addr(host_addr),
        .host_rdata(host_rdata), .busy(busy), .addr_hit(addr_hit), .wr_pulse(wr_pulse)
    );

    always #5 clk_50 = ~clk_50;
    always @(posedge clk_50) begin
        if (addr_hit) hit_cnt <= hit_cnt + 1;
        if (wr_pulse) wr_cnt <= wr_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wq;
        repeat (Q) @(negedge clk_50);
    endtask

    task automatic start_c;
        m_sda = 1'b1; wq; scl = 1'b1; wq; m_sda = 1'b0; wq; scl = 1'b0; wq;
    endtask

    task automatic stop_c;
        m_sda = 1'b0; wq; scl = 1'b1; wq; m_sda = 1'b1; wq;
    endtask

    task automatic put_bit(input logic b);
        m_sda = b; wq; scl = 1'b1; wq; wq; scl = 1'b0; wq;
    endtask

    task automatic get_bit(output logic b);
        m_sda = 1'b1; wq; scl = 1'b1; wq; b = sda; wq; scl = 1'b0; wq;
    endtask

    task automatic put_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) put_bit(d[i]);
        get_bit(ack);
    endtask

    task automatic get_byte(output logic [7:0] d, input logic last);
        logic b;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            get_bit(b);
            d = {d[6:0], b};
        end
        put_bit(last);
    endtask

    task automatic check_regs;
        for (int a = 0; a < 4; a++) begin
            host_addr = 2'(a);
            #1;
            check("host_rdata", host_rdata, mregs[a]);
        end
    endtask

    task automatic do_write(input logic [7:0] p, input int n);
        logic ack;
        int h, w;
        h = hit_cnt;
        w = wr_cnt;
        start_c;
        put_byte(8'hA0, ack); check("w_addr_ack", ack, 0);
        put_byte(p, ack); check("ptr_ack", ack, 0);
        mptr = p % 4;
        for (int i = 0; i < n; i++) begin
            put_byte(wbuf[i], ack); check("data_ack", ack, 0);
            mregs[mptr] = wbuf[i];
            mptr = (mptr + 1) % 4;
        end
        stop_c;
        check("w_hit_cnt", hit_cnt - h, 1);
        check("w_wr_cnt", wr_cnt - w, n);
        check("w_busy_idle", busy, 0);
        check_regs;
    endtask

    task automatic do_read(input logic set_ptr, input logic [7:0] p, input int n);
        logic ack;
        logic [7:0] d;
        int h;
        h = hit_cnt;
        start_c;
        if (set_ptr) begin
            put_byte(8'hA0, ack); check("rp_addr_ack", ack, 0);
            put_byte(p, ack); check("rp_ptr_ack", ack, 0);
            mptr = p % 4;
            start_c;
        end
        put_byte(8'hA1, ack); check("r_addr_ack", ack, 0);
        for (int i = 0; i < n; i++) begin
            get_byte(d, i == n - 1);
            check("rdata", d, mregs[mptr]);
            mptr = (mptr + 1) % 4;
        end
        stop_c;
        check("r_hit_cnt", hit_cnt - h, set_ptr ? 2 : 1);
        check("r_busy_idle", busy, 0);
    endtask

    initial begin
        logic ack;
        int n, w;
        logic [7:0] p;
        foreach (mregs[i]) mregs[i] = 8'h00;
        repeat (4) @(negedge clk_50);
        check("rst_busy", busy, 0);
        check("rst_addr_hit", addr_hit, 0);
        check("rst_wr_pulse", wr_pulse, 0);
        check("rst_sda", sda, 1);
        check_regs;
        reset = 1'b1;
        wq;

        wbuf[0] = 8'h3C; wbuf[1] = 8'h5D;
        do_write(8'h01, 2);
        do_read(1'b0, 8'h00, 1);
        do_read(1'b1, 8'h00, 2);

        w = wr_cnt;
        start_c;
        put_byte(8'hA2, ack); check("wrong_addr_nack", ack, 1);
        check("wrong_addr_busy", busy, 1);
        stop_c;
        check("wrong_addr_idle", busy, 0);
        check("wrong_addr_wr", wr_cnt - w, 0);
        check_regs;

        wbuf[0] = 8'h11; wbuf[1] = 8'h22;
        do_write(8'h03, 2);

        w = wr_cnt;
        start_c;
        put_byte(8'hA0, ack); check("abort_addr_ack", ack, 0);
        put_byte(8'h02, ack); check("abort_ptr_ack", ack, 0);
        mptr = 2;
        put_bit(1'b1); put_bit(1'b0); put_bit(1'b1); put_bit(1'b0);
        stop_c;
        check("abort_wr", wr_cnt - w, 0);
        check("abort_busy", busy, 0);
        check("abort_sda", sda, 1);
        check_regs;
        do_read(1'b0, 8'h00, 1);

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
        @(negedge clk_50) m_sda = 1'b0;
        @(negedge clk_50) m_sda = 1'b1;
        wq;
        check("glitch_busy", busy, 0);
`endif

        start_c;
        put_byte(8'hA0, ack);
        put_byte(8'h00, ack);
        start_c;
        put_byte(8'hA1, ack); check("rst_rd_ack", ack, 0);
        wq;
        check("rst_rd_drive", sda, mregs[0][7]);
        @(negedge clk_50) reset = 1'b0;
        @(negedge clk_50);
        check("rst_mid_sda", sda, 1);
        check("rst_mid_busy", busy, 0);
        foreach (mregs[i]) mregs[i] = 8'h00;
        mptr = 0;
        check_regs;
        reset = 1'b1;
        m_sda = 1'b1;
        scl = 1'b1;
        wq;

        for (int t = 0; t < 24; t++) begin
            n = int'($urandom_range(1, 3));
            p = 8'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
                do_write(p, n);
            end else do_read(1'($urandom_range(0, 1)), p, n);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
